// File: rtl/memory_bus_responder_if.sv
// Memory bus between the core's initiator port and the memory responder.
// The fault signal exists only when MEMORY_BUS_RESPONDER_FAULT_EN is defined.
interface memory_bus_responder_if #(
   parameter int ADDRESS_SIZE = 15
);
   logic [ADDRESS_SIZE-1:0] address;
   logic                    strobe;
   logic                    writeEnable;
   logic [3:0]              byteMask;
   logic [31:0]             dataWrite;
   logic [31:0]             dataRead;
   logic                    ready;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
   logic                    fault;

   modport master (
      output address, strobe, writeEnable, byteMask, dataWrite,
      input  dataRead, ready, fault
   );
   modport slave (
      input  address, strobe, writeEnable, byteMask, dataWrite,
      output dataRead, ready, fault
   );
`else
   modport master (
      output address, strobe, writeEnable, byteMask, dataWrite,
      input  dataRead, ready
   );
   modport slave (
      input  address, strobe, writeEnable, byteMask, dataWrite,
      output dataRead, ready
   );
`endif
endinterface

// File: rtl/memory_bus_responder.sv
// Target end of the CPU memory bus: single-port synchronous word RAM with a
// strobe/ready handshake. Writes complete one cycle after acceptance, reads two.
// Optional fault reporting is enabled with MEMORY_BUS_RESPONDER_FAULT_EN.
module memory_bus_responder #(
   parameter int ADDRESS_SIZE = 15,
   parameter int MEM_WORDS    = 2048
) (
   input  logic                   clock,
   input  logic                   reset,
   memory_bus_responder_if.slave  bus
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int IW = ADDRESS_SIZE - 2;

   typedef enum logic [1:0] {IDLE, WRESP, RDATA, RELEASE} state_e;

   state_e        state_q, state_d;
   logic          ready_q, ready_d;
   logic [31:0]   data_read_q, data_read_d;
   logic          rd_oor_q, rd_oor_d;
   logic [31:0]   mem [MEM_WORDS];
   logic [31:0]   ram_dout;

   logic [IW-1:0] word_idx;
   logic [AW-1:0] ram_idx;
   logic          in_range;
   logic          accept;
   logic          wr_bad;
   logic          ram_we;
   logic          ram_re;

   assign word_idx = bus.address[ADDRESS_SIZE-1:2];
   assign ram_idx  = word_idx[AW-1:0];
   // MEM_WORDS is a power of two, so in range means no index bits above the RAM width
   assign in_range = (word_idx >> AW) == '0;
   // Requests are only taken in IDLE, and never in a reset cycle
   assign accept   = (state_q == IDLE) && bus.strobe && !reset;

`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
   logic misaligned;
   logic fault_q, fault_d;
   // A misaligned write cannot be expressed as a single word write; drop and flag it
   assign misaligned = bus.address[1:0] != 2'b00;
   assign wr_bad     = !in_range || misaligned;
   assign bus.fault  = fault_q;
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.address[1:0];
   assign wr_bad          = !in_range;
`endif

   assign ram_we       = accept && bus.writeEnable && !wr_bad;
   assign ram_re       = accept && !bus.writeEnable;
   assign bus.ready    = ready_q;
   assign bus.dataRead = data_read_q;

   // Word RAM with byte-masked write and registered read; no reset so it maps to block RAM
   always_ff @(posedge clock) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.byteMask[b]) mem[ram_idx][8*b +: 8] <= bus.dataWrite[8*b +: 8];
         end
      end
      if (ram_re) ram_dout <= mem[ram_idx];
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ready_q     <= 1'b0;
         data_read_q <= 32'h0;
         rd_oor_q    <= 1'b0;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
         fault_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ready_q     <= ready_d;
         data_read_q <= data_read_d;
         rd_oor_q    <= rd_oor_d;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
         fault_q     <= fault_d;
`endif
      end
   end

   // Next-state: one transaction per strobe, then wait for strobe to drop
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.strobe) state_d = bus.writeEnable ? WRESP : RDATA;
         WRESP:   state_d = RELEASE;
         RDATA:   state_d = RELEASE;
         RELEASE: if (!bus.strobe) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: ready pulse, read data capture, and the range flag carried to RDATA
   always_comb begin
      ready_d     = 1'b0;
      data_read_d = data_read_q;
      rd_oor_d    = rd_oor_q;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
      fault_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.strobe && bus.writeEnable) begin
               ready_d = 1'b1;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
               fault_d = wr_bad;
`endif
            end else if (bus.strobe) begin
               rd_oor_d = !in_range;
            end
         end
         RDATA: begin
            ready_d     = 1'b1;
            data_read_d = rd_oor_q ? 32'h0 : ram_dout;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
            fault_d     = rd_oor_q;
`endif
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_memory_bus_responder.sv
// Bench for memory_bus_responder: directed transactions, a timeline/array model
// of the responder checked every cycle, and literal checks on key results.
module tb_memory_bus_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   memory_bus_responder_if #(.ADDRESS_SIZE(15)) bus();

   memory_bus_responder #(.ADDRESS_SIZE(15), .MEM_WORDS(2048)) dut (
      .clock(clk),
      .reset(rst),
      .bus(bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: memory array plus a timeline of when ready is due
   logic [31:0] mm [0:2047];
   int          cyc = 0;
   int          acc_cyc = 0;
   int          rdy_at = -1;
   bit          busy = 0;
   bit          pend_rd = 0;
   bit          pend_flt = 0;
   bit          chk_en = 0;
   logic [31:0] pend_val = 32'h0;
   logic        m_ready = 1'b0;
   logic [31:0] m_data = 32'h0;
   logic        m_fault = 1'b0;

   always @(posedge clk) begin
      int idx;
      bit oor, mis;
      if (rst) begin
         busy = 0; rdy_at = -1;
         m_ready = 1'b0; m_data = 32'h0; m_fault = 1'b0;
         chk_en = 1;
      end else begin
         if (busy) begin
            if (cyc >= acc_cyc + 2 && !bus.strobe) busy = 0;
         end else if (bus.strobe) begin
            busy = 1; acc_cyc = cyc;
            idx = int'(bus.address >> 2);
            oor = idx >= 2048;
            mis = bus.address[1:0] != 2'b00;
            if (bus.writeEnable) begin
               pend_rd = 0; rdy_at = cyc + 1; pend_flt = oor || mis;
               if (!oor && !(FAULT_EN && mis))
                  for (int b = 0; b < 4; b++)
                     if (bus.byteMask[b]) mm[idx][8*b +: 8] = bus.dataWrite[8*b +: 8];
            end else begin
               pend_rd = 1; rdy_at = cyc + 2; pend_flt = oor;
               pend_val = oor ? 32'h0 : mm[idx];
            end
         end
         m_ready = (cyc + 1 == rdy_at);
         if (m_ready && pend_rd) m_data = pend_val;
         m_fault = m_ready && pend_flt;
      end
      cyc++;
   end

   // Compare DUT outputs against the model every cycle once reset has been seen
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", {31'b0, bus.ready}, {31'b0, m_ready});
         chk("dataRead", bus.dataRead, m_data);
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
         chk("fault", {31'b0, bus.fault}, {31'b0, m_fault});
`endif
      end
   end

   task automatic xfer(input bit we, input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] m, output logic [31:0] rd, output int lat,
                       output logic flt);
      bus.address = a; bus.writeEnable = we; bus.dataWrite = d; bus.byteMask = m;
      bus.strobe = 1'b1;
      lat = 0; rd = 32'h0; flt = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.ready) begin
            lat = i; rd = bus.dataRead;
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
            flt = bus.fault;
`endif
            break;
         end
      end
      if (lat == 0) begin
         n_chk++; n_err++;
         $display("FAIL timeout: no ready for addr %h within 20 cycles", a);
      end
      bus.strobe = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic count_ready(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.ready) cnt++;
      end
   endtask

   initial begin
      logic [31:0] rd;
      int lat, cnt;
      logic flt;
      for (int i = 0; i < 2048; i++) mm[i] = 32'h0;
      bus.address = '0; bus.strobe = 1'b0; bus.writeEnable = 1'b0;
      bus.byteMask = 4'h0; bus.dataWrite = 32'h0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_ready", {31'b0, bus.ready}, 32'h0);
      chk("reset_data", bus.dataRead, 32'h0);

      xfer(1, 15'h0010, 32'hDEADBEEF, 4'hF, rd, lat, flt);
      chk("wr_latency", lat, 1);
      xfer(0, 15'h0010, 32'h0, 4'h0, rd, lat, flt);
      chk("rd_latency", lat, 2);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);

      xfer(1, 15'h0020, 32'h11223344, 4'hF, rd, lat, flt);
      xfer(1, 15'h0020, 32'hAABBCCDD, 4'b0101, rd, lat, flt);
      xfer(0, 15'h0020, 32'h0, 4'h0, rd, lat, flt);
      chk("rd_masked", rd, 32'h11BB33DD);
      xfer(1, 15'h0020, 32'hFFFFFFFF, 4'b0000, rd, lat, flt);
      chk("wr_mask0_latency", lat, 1);
      xfer(0, 15'h0020, 32'h0, 4'h0, rd, lat, flt);
      chk("rd_mask0", rd, 32'h11BB33DD);

      xfer(1, 15'h1F00, 32'h5, 4'hF, rd, lat, flt);
      xfer(0, 15'h1F00, 32'h0, 4'h0, rd, lat, flt);
      chk("rd_idx1984", rd, 32'h5);
      xfer(1, 15'h1FFC, 32'h12345678, 4'hF, rd, lat, flt);
      xfer(0, 15'h7FFC, 32'h0, 4'h0, rd, lat, flt);
      chk("rd_oor_data", rd, 32'h0);
      chk("rd_oor_latency", lat, 2);
      xfer(1, 15'h7FFC, 32'hFFFFFFFF, 4'hF, rd, lat, flt);
      chk("wr_oor_latency", lat, 1);
`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
      chk("wr_oor_fault", {31'b0, flt}, 32'h1);
`endif
      xfer(0, 15'h1FFC, 32'h0, 4'h0, rd, lat, flt);
      chk("no_alias", rd, 32'h12345678);

      // strobe held for six cycles on a read
      bus.address = 15'h0010; bus.writeEnable = 1'b0; bus.strobe = 1'b1;
      count_ready(6, cnt);
      bus.strobe = 1'b0;
      repeat (2) @(negedge clk);
      chk("held_strobe_pulses", cnt, 1);
      xfer(0, 15'h1F00, 32'h0, 4'h0, rd, lat, flt);
      chk("after_hold_latency", lat, 2);
      chk("after_hold_data", rd, 32'h5);

      // reset during RDATA abandons the read
      bus.address = 15'h0020; bus.writeEnable = 1'b0; bus.strobe = 1'b1;
      @(negedge clk);
      rst = 1'b1; bus.strobe = 1'b0;
      @(negedge clk);
      chk("rdata_reset_ready", {31'b0, bus.ready}, 32'h0);
      chk("rdata_reset_data", bus.dataRead, 32'h0);
      rst = 1'b0;
      count_ready(4, cnt);
      chk("rdata_reset_no_pulse", cnt, 0);
      xfer(0, 15'h0010, 32'h0, 4'h0, rd, lat, flt);
      chk("survives_reset", rd, 32'hDEADBEEF);

      // reset and strobe together: request ignored
      bus.address = 15'h0010; bus.writeEnable = 1'b1; bus.dataWrite = 32'h0;
      bus.byteMask = 4'hF; bus.strobe = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.strobe = 1'b0;
      count_ready(4, cnt);
      chk("reset_strobe_no_pulse", cnt, 0);
      xfer(0, 15'h0010, 32'h0, 4'h0, rd, lat, flt);
      chk("reset_strobe_no_write", rd, 32'hDEADBEEF);

`ifdef MEMORY_BUS_RESPONDER_FAULT_EN
      xfer(1, 15'h0040, 32'hCAFEF00D, 4'hF, rd, lat, flt);
      chk("aligned_no_fault", {31'b0, flt}, 32'h0);
      xfer(1, 15'h0041, 32'h0BADBEEF, 4'hF, rd, lat, flt);
      chk("misaligned_fault", {31'b0, flt}, 32'h1);
      xfer(0, 15'h0040, 32'h0, 4'h0, rd, lat, flt);
      chk("misaligned_dropped", rd, 32'hCAFEF00D);
      chk("rd_inrange_no_fault", {31'b0, flt}, 32'h0);
`endif

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end
endmodule
